// File: rtl/blackjack_table_fsm.sv
// blackjack_table_fsm: game-flow controller for a table of 1..NUM_SEATS seats
// plus a dealer. Sequences seat selection, initial deal, per-seat turns, the
// dealer turn and the per-seat result. Cards are requested through a
// draw_req / cards_updated handshake; hand scores arrive on the score inputs.
// Optional feature macro: BJ_PUSH_EN (ties set push_mask instead of losing).
module blackjack_table_fsm #(
    parameter  int NUM_SEATS    = 4,
    parameter  int SCORE_W      = 5,
    parameter  int DEALER_STAND = 17,
    localparam int TW           = $clog2(NUM_SEATS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hold,
    input  logic                         hit,
    input  logic                         hold_ai,
    input  logic                         hit_ai,
    input  logic [NUM_SEATS-1:0]         ai_mask,
    input  logic                         cards_updated,
    input  logic [NUM_SEATS*SCORE_W-1:0] seat_high,
    input  logic [NUM_SEATS*SCORE_W-1:0] seat_low,
    input  logic [SCORE_W-1:0]           d_high,
    input  logic [SCORE_W-1:0]           d_low,
    output logic                         draw_req,
    output logic [TW-1:0]                draw_target,
    output logic [2:0]                   current_state,
    output logic [TW-1:0]                active_seat,
    output logic [TW-1:0]                seat_count,
    output logic [NUM_SEATS-1:0]         win_mask,
    output logic [NUM_SEATS-1:0]         push_mask
);

    // Deal counter must reach 2*(NUM_SEATS+1).
    localparam int KW = $clog2(2 * (NUM_SEATS + 1) + 1);

    typedef enum logic [2:0] {
        S_SELECT      = 3'd0,
        S_DEAL        = 3'd1,
        S_DEAL_WAIT   = 3'd2,
        S_TURN        = 3'd3,
        S_DRAW_WAIT   = 3'd4,
        S_DEALER      = 3'd5,
        S_DEALER_WAIT = 3'd6,
        S_RESULT      = 3'd7
    } state_t;

    state_t               state_q,       state_d;
    logic [TW-1:0]        seat_count_q,  seat_count_d;
    logic [TW-1:0]        active_seat_q, active_seat_d;
    logic [KW-1:0]        deal_k_q,      deal_k_d;
    logic [TW-1:0]        deal_tgt_q,    deal_tgt_d;
    logic [NUM_SEATS-1:0] ai_q,          ai_d;
    logic                 draw_req_q,    draw_req_d;
    logic [TW-1:0]        draw_target_q, draw_target_d;
    logic [NUM_SEATS-1:0] win_q,         win_d;
    logic [NUM_SEATS-1:0] push_q,        push_d;

    // Best score of a hand as {bust, score}: ace-high if it fits, else ace-low.
    function automatic logic [SCORE_W:0] best_score(input logic [SCORE_W-1:0] high,
                                                     input logic [SCORE_W-1:0] low);
        if (int'(high) <= 21)
            best_score = {1'b0, high};
        else if (low != '0 && int'(low) <= 21)
            best_score = {1'b0, low};
        else
            best_score = {1'b1, {SCORE_W{1'b0}}};
    endfunction

    logic [NUM_SEATS-1:0] seat_bust;
    logic [SCORE_W-1:0]   seat_best [NUM_SEATS];
    logic [NUM_SEATS-1:0] in_play;
    logic                 dealer_bust;
    logic [SCORE_W-1:0]   dealer_best;
    logic                 all_bust;
    logic                 act_bust;
    logic                 act_ai;
    logic                 act_hold;
    logic                 act_hit;
    logic [NUM_SEATS-1:0] win_next;
    logic [NUM_SEATS-1:0] push_next;
    logic [KW-1:0]        deal_total;

    // Hand evaluation for every seat, the dealer and the active seat.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        seat_bust   = '0;
        in_play     = '0;
        win_next    = '0;
        push_next   = '0;
        act_bust    = 1'b0;
        act_ai      = 1'b0;
        {dealer_bust, dealer_best} = best_score(d_high, d_low);
        for (int i = 0; i < NUM_SEATS; i++) begin
            {seat_bust[i], seat_best[i]} =
                best_score(seat_high[i*SCORE_W +: SCORE_W], seat_low[i*SCORE_W +: SCORE_W]);
            in_play[i] = (i < int'(seat_count_q));
            win_next[i] = in_play[i] && !seat_bust[i] &&
                          (dealer_bust || seat_best[i] > dealer_best);
`ifdef BJ_PUSH_EN
            push_next[i] = in_play[i] && !seat_bust[i] && !dealer_bust &&
                           (seat_best[i] == dealer_best);
`endif
            if (active_seat_q == TW'(i)) begin
                act_bust = seat_bust[i];
                act_ai   = ai_q[i];
            end
        end
        all_bust   = &(seat_bust | ~in_play);
        act_hold   = act_ai ? hold_ai : hold;
        act_hit    = act_ai ? hit_ai  : hit;
        deal_total = KW'((int'(seat_count_q) + 1) * 2);
    end

    // Next-state and registered-output logic of the game-flow FSM.
    always_comb begin
        state_d       = state_q;
        seat_count_d  = seat_count_q;
        active_seat_d = active_seat_q;
        deal_k_d      = deal_k_q;
        deal_tgt_d    = deal_tgt_q;
        ai_d          = ai_q;
        draw_req_d    = 1'b0;
        draw_target_d = draw_target_q;
        win_d         = win_q;
        push_d        = push_q;

        case (state_q)
            S_SELECT: begin
                if (hit) begin
                    ai_d       = ai_mask;
                    deal_k_d   = '0;
                    deal_tgt_d = '0;
                    state_d    = S_DEAL;
                end else if (hold) begin
                    seat_count_d = (seat_count_q == TW'(NUM_SEATS)) ? TW'(1)
                                                                   : seat_count_q + TW'(1);
                end
            end
            S_DEAL: begin
                draw_req_d    = 1'b1;
                draw_target_d = (deal_tgt_q == seat_count_q) ? TW'(NUM_SEATS) : deal_tgt_q;
                state_d       = S_DEAL_WAIT;
            end
            S_DEAL_WAIT: begin
                if (cards_updated) begin
                    deal_k_d   = deal_k_q + KW'(1);
                    deal_tgt_d = (deal_tgt_q == seat_count_q) ? '0 : deal_tgt_q + TW'(1);
                    if (deal_k_q + KW'(1) == deal_total) begin
                        active_seat_d = '0;
                        state_d       = S_TURN;
                    end else begin
                        state_d = S_DEAL;
                    end
                end
            end
            S_TURN: begin
                if (act_bust || act_hold) begin
                    if (active_seat_q + TW'(1) == seat_count_q)
                        state_d = S_DEALER;
                    else
                        active_seat_d = active_seat_q + TW'(1);
                end else if (act_hit) begin
                    draw_req_d    = 1'b1;
                    draw_target_d = active_seat_q;
                    state_d       = S_DRAW_WAIT;
                end
            end
            S_DRAW_WAIT: begin
                if (cards_updated)
                    state_d = S_TURN;
            end
            S_DEALER: begin
                if (all_bust || dealer_bust || int'(dealer_best) >= DEALER_STAND) begin
                    win_d   = win_next;
                    push_d  = push_next;
                    state_d = S_RESULT;
                end else begin
                    draw_req_d    = 1'b1;
                    draw_target_d = TW'(NUM_SEATS);
                    state_d       = S_DEALER_WAIT;
                end
            end
            S_DEALER_WAIT: begin
                if (cards_updated)
                    state_d = S_DEALER;
            end
            S_RESULT: begin
                if (hold && hit) begin
                    win_d   = '0;
                    push_d  = '0;
                    state_d = S_SELECT;
                end
            end
            default: state_d = S_SELECT;
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_SELECT;
            seat_count_q  <= TW'(1);
            active_seat_q <= '0;
            deal_k_q      <= '0;
            deal_tgt_q    <= '0;
            ai_q          <= '0;
            draw_req_q    <= 1'b0;
            draw_target_q <= '0;
            win_q         <= '0;
            push_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            seat_count_q  <= seat_count_d;
            active_seat_q <= active_seat_d;
            deal_k_q      <= deal_k_d;
            deal_tgt_q    <= deal_tgt_d;
            ai_q          <= ai_d;
            draw_req_q    <= draw_req_d;
            draw_target_q <= draw_target_d;
            win_q         <= win_d;
            push_q        <= push_d;
        end
    end

    assign current_state = state_q;
    assign seat_count    = seat_count_q;
    assign active_seat   = active_seat_q;
    assign draw_req      = draw_req_q;
    assign draw_target   = draw_target_q;
    assign win_mask      = win_q;
    assign push_mask     = push_q;

endmodule
